// File: rtl/secure_dmem_responder.sv
// rtl/secure_dmem_responder.sv - wait-stated data RAM responder with keyed upper region
module secure_dmem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter int          PROT_BASE   = 192,
    parameter logic [31:0] KEY         = 32'hA5C3_0F1E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_key,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);
    localparam logic [29:0] PROT_IDX  = 30'(PROT_BASE);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata, lat_key;
    logic [31:0] mem [DEPTH];

    logic        hs, exec;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata, acc_key;
    logic [29:0] acc_idx;
    logic        acc_bad;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nx = state;
        hs       = 1'b0;
        exec     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    hs = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        exec     = 1'b1;
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    exec     = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // With zero wait states the access uses the request as presented, not the latch.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_key   = lat_key;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_key   = req_key;
        end
        acc_idx = acc_addr[31:2];
        acc_bad = (acc_addr[1:0] != 2'b00)
               || (acc_idx >= DEPTH_IDX)
               || ((acc_idx >= PROT_IDX) && (acc_key != KEY));
    end

    always_ff @(posedge clk) begin
        if (reset && exec && acc_we && !acc_bad)
            mem[acc_idx[AW-1:0]] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_key   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state <= state_nx;
            if (hs) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_key   <= req_key;
                cnt       <= WAIT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec) begin
                rsp_err   <= acc_bad;
                rsp_rdata <= (acc_bad || acc_we) ? 32'd0 : mem[acc_idx[AW-1:0]];
                if (acc_bad && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_secure_dmem_responder.sv
// tb/tb_secure_dmem_responder.sv - scoreboard bench for secure_dmem_responder
module tb_secure_dmem_responder;
    localparam logic [31:0] K = 32'hA5C3_0F1E;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_key = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_count;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic [7:0]  err_count0;

    secure_dmem_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_count(err_count)
    );

    secure_dmem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_key(32'd0),
        .rsp_valid(rsp_valid0), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .err_count(err_count0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          hs;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int exp_ec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on the first response cycle, data/err at the response handshake.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                prev = 1'b0;
            end else begin
                if (rsp_valid && !prev) begin
                    if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                    else chk("latency", 32'(cyc - sb[0].hs), 32'd3);
                end
                if (rsp_valid && rsp_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rd);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
                prev = rsp_valid;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] k, input logic [31:0] exp_rd, input logic exp_e);
        int n = 0;
        req_we = we; req_addr = a; req_wdata = wd; req_key = k; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("issue_timeout", 32'd1, 32'd0);
        else sb.push_back('{rd: exp_rd, err: exp_e, hs: cyc});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] k, input logic [31:0] exp_rd, input logic exp_e);
        issue(we, a, wd, k, exp_rd, exp_e);
        wait_idle();
        if (exp_e && exp_ec < 255) exp_ec++;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        txn(1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        txn(0, 32'h10, 0, 0, 32'hDEADBEEF, 0);

        txn(1, 32'h300, 32'h1234_5678, K, 0, 0);
        txn(0, 32'h300, 0, 0, 0, 1);
        chk("ec_after_keyfault", {24'd0, err_count}, 32'd1);
        txn(0, 32'h300, 0, K, 32'h1234_5678, 0);

        txn(1, 32'h13, 32'hFFFF_FFFF, 0, 0, 1);
        txn(0, 32'h10, 0, 0, 32'hDEADBEEF, 0);
        txn(0, 32'h400, 0, 0, 0, 1);
        chk("ec_after_addr_errs", {24'd0, err_count}, 32'd3);

        // Backpressure with a second request already waiting on the port.
        rsp_ready = 1'b0;
        issue(0, 32'h10, 0, 0, 32'hDEADBEEF, 0);
        req_we = 1'b0; req_addr = 32'h300; req_key = K; req_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after_release", {31'd0, req_ready}, 32'd1);
        sb.push_back('{rd: 32'h1234_5678, err: 1'b0, hs: cyc});
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        // Reset mid-WAIT aborts the store.
        txn(1, 32'h20, 32'h1111_2222, 0, 0, 0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_ec = 0;
        chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstw_err_count", {24'd0, err_count}, 32'd0);
        repeat (6) @(negedge clk);
        txn(0, 32'h20, 0, 0, 32'h1111_2222, 0);

        for (int i = 0; i < 260; i++) begin
            txn(0, 32'h304, 0, 0, 0, 1);
            if (i == 253) chk("ec_254", {24'd0, err_count}, 32'd254);
        end
        chk("ec_saturated", {24'd0, err_count}, 32'd255);
        chk("ec_model", 32'(exp_ec), {24'd0, err_count});

        // Zero-wait-state build: one-cycle latency.
        req_we0 = 1'b1; req_addr0 = 32'h10; req_wdata0 = 32'h5A5A_0001; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("w0_store_valid", {31'd0, rsp_valid0}, 32'd1);
        chk("w0_store_err", {31'd0, rsp_err0}, 32'd0);
        @(negedge clk);
        chk("w0_ready_again", {31'd0, req_ready0}, 32'd1);
        req_we0 = 1'b0; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("w0_load_valid", {31'd0, rsp_valid0}, 32'd1);
        chk("w0_load_rdata", rsp_rdata0, 32'h5A5A_0001);
        req_addr0 = 32'h11; req_valid0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("w0_misalign_valid", {31'd0, rsp_valid0}, 32'd1);
        chk("w0_misalign_err", {31'd0, rsp_err0}, 32'd1);
        @(negedge clk);
        chk("w0_err_count", {24'd0, err_count0}, 32'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/secure_dmem_responder.md
# secure_dmem_responder

Memory-side responder for the processor's load/store port. It accepts one word request at a time over a valid/ready handshake and applies a fixed, programmable wait-state latency. Writes to the protected upper region, and reads from it, require a matching access key. Every completed request returns a response with read data and an error flag. The block sits between the core's load/store path and on-chip data RAM, and carries the data-protection function of the secured core.

## Interface
- DEPTH, 256, number of 32-bit words in the array (power of two, ≥4)
- WAIT_CYCLES, 2, wait states between request acceptance and response (0–15)
- PROT_BASE, 192, first protected word index; indices PROT_BASE..DEPTH-1 need the key
- KEY, 32'hA5C3_0F1E, access key for the protected region

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_key  in  32  access key presented with the request
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts the response
- rsp_rdata  out  32  load data; 0 for stores and errored requests
- rsp_err  out  1  request rejected
- err_count  out  8  count of rejected requests, saturating at 255

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: wait-state countdown.
  - RESP: rsp_valid=1.
- IDLE: a handshake (req_valid & req_ready at the edge) latches we, addr, wdata and key.
  - Next state is WAIT with counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0, next state is RESP directly.
- WAIT: the counter decrements each cycle. At the edge where the counter is 1, the access executes and the state goes to RESP.
- Access executes at the RESP-entry edge:
  - Word index = addr[31:2].
  - Error conditions, in priority order: addr[1:0]≠0 (misaligned); index ≥ DEPTH (out of range); index ≥ PROT_BASE and key≠KEY (key fault).
  - On error: no array write, rsp_rdata=0, rsp_err=1, err_count increments unless it is already 255.
  - Store OK: mem[index]←wdata, rsp_rdata=0, rsp_err=0.
  - Load OK: rsp_rdata=mem[index], rsp_err=0.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1, then the state goes to IDLE.
- Errored requests take exactly the same latency as successful ones. This uniform timing is required so that timing gives no side channel on key or region.
- Only one request is outstanding at a time. No request is accepted in WAIT or RESP.

## Timing
- Reset (reset=0 at an edge) forces:
  - state=IDLE, counter=0
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0
- Array contents are not reset.
- Reset during WAIT aborts the request with no write and no response. Reset during RESP drops the response.
- Latency: a handshake in cycle T gives rsp_valid high in cycle T+1+WAIT_CYCLES (T+3 with defaults).
- A store becomes visible to a load accepted at or after the store's RESP cycle.
- Back-to-back throughput:
  - A response accepted in cycle R returns req_ready high in R+1.
  - Peak rate is one request per WAIT_CYCLES+2 cycles.
- req_ready is a pure function of state. There is no combinational path from req_valid to req_ready, or from rsp_ready to rsp_valid.
- err_count updates at the RESP-entry edge, regardless of rsp_ready.

## Test plan
- Store then load, in range and unprotected:
  - Store addr 0x10, data 0xDEADBEEF, then load addr 0x10.
  - Required: rsp_rdata=0xDEADBEEF, rsp_err=0, each rsp_valid exactly 3 cycles after its handshake.
- Protected region:
  - Store addr 0x300 (index 192), correct key, data 0x1234_5678: succeeds.
  - Load with key 0: rsp_err=1, rsp_rdata=0, err_count=1.
  - Load with correct key: returns 0x1234_5678.
- Misaligned and out-of-range:
  - Store addr 0x13: rsp_err=1, and a subsequent load of 0x10 is unchanged.
  - Load addr 0x400 (index 256): rsp_err=1.
  - err_count advances by 2. Error latency equals success latency.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_rdata and rsp_err stay stable, and req_ready stays 0 while req_valid is held high.
  - After release, the next request is accepted one cycle later.
- Reset mid-WAIT:
  - Accept a store to 0x20 with data 0xCAFEF00D, assert reset=0 the next cycle.
  - Required: rsp_valid is never raised, req_ready=1 after reset, and a later load of 0x20 returns its pre-store value.
- Saturation:
  - Issue 260 key-fault loads.
  - err_count reaches 255 and holds. Set WAIT_CYCLES=0 in a second build and verify latency of 1 cycle.
